// File: rtl/pipeline_pkg.sv
// Shared pipeline constants: branch-type encodings and default datapath widths.
package pipeline_pkg;

  localparam int unsigned DataWDef = 32;
  localparam int unsigned RegAwDef = 5;
  localparam int unsigned ExCmdW   = 4;
  localparam int unsigned BrTypeW  = 2;

  localparam logic [BrTypeW-1:0] BR_NONE = 2'b00;
  localparam logic [BrTypeW-1:0] BR_BEZ  = 2'b01;
  localparam logic [BrTypeW-1:0] BR_BNE  = 2'b10;
  localparam logic [BrTypeW-1:0] BR_JMP  = 2'b11;

endpackage

// File: rtl/hazard_detect_unit.sv
// Load-use hazard compare between the instruction in EX and the one in decode.
module hazard_detect_unit import pipeline_pkg::*; #(
  parameter int unsigned REG_AW = RegAwDef
) (
  input  logic              ex_valid_i,
  input  logic              ex_mem_read_i,
  input  logic [REG_AW-1:0] ex_dest_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_src1_i,
  input  logic [REG_AW-1:0] id_src2_i,
  input  logic              id_uses_src2_i,
  output logic              hazard_stall_o
);

  logic load_in_ex;
  logic src_match;

  // Register 0 is hard-wired, so a load targeting it never blocks a consumer.
  always_comb begin
    load_in_ex     = ex_valid_i && ex_mem_read_i && (ex_dest_i != '0);
    src_match      = (id_src1_i == ex_dest_i) || (id_uses_src2_i && (id_src2_i == ex_dest_i));
    hazard_stall_o = load_in_ex && id_valid_i && src_match;
  end

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with load-use stall, branch flush, freeze and event counters.
module id_ex_pipe_reg import pipeline_pkg::*; #(
  parameter int unsigned DATA_W = DataWDef,
  parameter int unsigned REG_AW = RegAwDef,
  parameter int unsigned CNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic               id_wb_en,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic [BrTypeW-1:0] id_branch_type,
  input  logic [ExCmdW-1:0]  id_ex_cmd,
  input  logic [DATA_W-1:0]  id_pc,
  input  logic [DATA_W-1:0]  id_reg1,
  input  logic [DATA_W-1:0]  id_reg2,
  input  logic [DATA_W-1:0]  id_mux_res,
  input  logic [REG_AW-1:0]  id_dest,
  input  logic [REG_AW-1:0]  id_src1,
  input  logic [REG_AW-1:0]  id_src2,
  input  logic               id_uses_src2,
  input  logic               freeze,
  input  logic               flush,
  output logic               hazard_stall,
  output logic               ex_valid,
  output logic               ex_wb_en,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic [BrTypeW-1:0] ex_branch_type,
  output logic [ExCmdW-1:0]  ex_ex_cmd,
  output logic [DATA_W-1:0]  ex_pc,
  output logic [DATA_W-1:0]  ex_reg1,
  output logic [DATA_W-1:0]  ex_reg2,
  output logic [DATA_W-1:0]  ex_mux_res,
  output logic [REG_AW-1:0]  ex_dest,
  output logic [CNT_W-1:0]   bubble_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  logic               valid_q, valid_d;
  logic               wb_en_q, wb_en_d;
  logic               mem_read_q, mem_read_d;
  logic               mem_write_q, mem_write_d;
  logic [BrTypeW-1:0] br_q, br_d;
  logic [ExCmdW-1:0]  cmd_q, cmd_d;
  logic [DATA_W-1:0]  pc_q, pc_d;
  logic [DATA_W-1:0]  reg1_q, reg1_d;
  logic [DATA_W-1:0]  reg2_q, reg2_d;
  logic [DATA_W-1:0]  mux_q, mux_d;
  logic [REG_AW-1:0]  dest_q, dest_d;
  logic [CNT_W-1:0]   bubble_cnt_q, bubble_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  hazard_detect_unit #(
    .REG_AW(REG_AW)
  ) u_hazard (
    .ex_valid_i     (valid_q),
    .ex_mem_read_i  (mem_read_q),
    .ex_dest_i      (dest_q),
    .id_valid_i     (id_valid),
    .id_src1_i      (id_src1),
    .id_src2_i      (id_src2),
    .id_uses_src2_i (id_uses_src2),
    .hazard_stall_o (hazard_stall)
  );

  // Next state: freeze holds everything, then flush, then hazard bubble, else load decode.
  always_comb begin
    valid_d      = valid_q;
    wb_en_d      = wb_en_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    br_d         = br_q;
    cmd_d        = cmd_q;
    pc_d         = pc_q;
    reg1_d       = reg1_q;
    reg2_d       = reg2_q;
    mux_d        = mux_q;
    dest_d       = dest_q;
    bubble_cnt_d = bubble_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (!freeze) begin
      if (flush || hazard_stall) begin
        valid_d     = 1'b0;
        wb_en_d     = 1'b0;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        br_d        = BR_NONE;
        cmd_d       = '0;
        pc_d        = '0;
        reg1_d      = '0;
        reg2_d      = '0;
        mux_d       = '0;
        dest_d      = '0;
        // A flush hides any coincident hazard, so only one event is counted.
        if (flush) begin
          if (!(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
        end else begin
          if (!(&bubble_cnt_q)) bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
      end else begin
        valid_d     = id_valid;
        wb_en_d     = id_valid && id_wb_en;
        mem_read_d  = id_valid && id_mem_read;
        mem_write_d = id_valid && id_mem_write;
        br_d        = id_valid ? id_branch_type : BR_NONE;
        cmd_d       = id_ex_cmd;
        pc_d        = id_pc;
        reg1_d      = id_reg1;
        reg2_d      = id_reg2;
        mux_d       = id_mux_res;
        dest_d      = id_dest;
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q      <= 1'b0;
      wb_en_q      <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      br_q         <= BR_NONE;
      cmd_q        <= '0;
      pc_q         <= '0;
      reg1_q       <= '0;
      reg2_q       <= '0;
      mux_q        <= '0;
      dest_q       <= '0;
      bubble_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      valid_q      <= valid_d;
      wb_en_q      <= wb_en_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      br_q         <= br_d;
      cmd_q        <= cmd_d;
      pc_q         <= pc_d;
      reg1_q       <= reg1_d;
      reg2_q       <= reg2_d;
      mux_q        <= mux_d;
      dest_q       <= dest_d;
      bubble_cnt_q <= bubble_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  // Output wiring.
  always_comb begin
    ex_valid       = valid_q;
    ex_wb_en       = wb_en_q;
    ex_mem_read    = mem_read_q;
    ex_mem_write   = mem_write_q;
    ex_branch_type = br_q;
    ex_ex_cmd      = cmd_q;
    ex_pc          = pc_q;
    ex_reg1        = reg1_q;
    ex_reg2        = reg2_q;
    ex_mux_res     = mux_q;
    ex_dest        = dest_q;
    bubble_cnt     = bubble_cnt_q;
    flush_cnt      = flush_cnt_q;
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Self-checking bench for id_ex_pipe_reg using a reference model and an expected-state queue.
module tb_id_ex_pipe_reg;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned CW = 8;

  typedef struct packed {
    logic          valid;
    logic          wb;
    logic          mr;
    logic          mw;
    logic [1:0]    br;
    logic [3:0]    cmd;
    logic [DW-1:0] pc;
    logic [DW-1:0] r1;
    logic [DW-1:0] r2;
    logic [DW-1:0] mux;
    logic [AW-1:0] dest;
    logic [CW-1:0] bcnt;
    logic [CW-1:0] fcnt;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          id_valid = 1'b0, id_wb_en = 1'b0, id_mem_read = 1'b0, id_mem_write = 1'b0;
  logic [1:0]    id_branch_type = '0;
  logic [3:0]    id_ex_cmd = '0;
  logic [DW-1:0] id_pc = '0, id_reg1 = '0, id_reg2 = '0, id_mux_res = '0;
  logic [AW-1:0] id_dest = '0, id_src1 = '0, id_src2 = '0;
  logic          id_uses_src2 = 1'b0, freeze = 1'b0, flush = 1'b0;
  logic          hazard_stall, ex_valid, ex_wb_en, ex_mem_read, ex_mem_write;
  logic [1:0]    ex_branch_type;
  logic [3:0]    ex_ex_cmd;
  logic [DW-1:0] ex_pc, ex_reg1, ex_reg2, ex_mux_res;
  logic [AW-1:0] ex_dest;
  logic [CW-1:0] bubble_cnt, flush_cnt;

  int   checks = 0;
  int   errors = 0;
  exp_t m = '0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.DATA_W(DW), .REG_AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_wb_en(id_wb_en), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_branch_type(id_branch_type), .id_ex_cmd(id_ex_cmd),
    .id_pc(id_pc), .id_reg1(id_reg1), .id_reg2(id_reg2), .id_mux_res(id_mux_res),
    .id_dest(id_dest), .id_src1(id_src1), .id_src2(id_src2), .id_uses_src2(id_uses_src2),
    .freeze(freeze), .flush(flush), .hazard_stall(hazard_stall), .ex_valid(ex_valid),
    .ex_wb_en(ex_wb_en), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch_type(ex_branch_type), .ex_ex_cmd(ex_ex_cmd), .ex_pc(ex_pc), .ex_reg1(ex_reg1),
    .ex_reg2(ex_reg2), .ex_mux_res(ex_mux_res), .ex_dest(ex_dest), .bubble_cnt(bubble_cnt),
    .flush_cnt(flush_cnt)
  );

  function automatic exp_t outs();
    exp_t g;
    g.valid = ex_valid;    g.wb = ex_wb_en;      g.mr = ex_mem_read;  g.mw = ex_mem_write;
    g.br = ex_branch_type; g.cmd = ex_ex_cmd;    g.pc = ex_pc;        g.r1 = ex_reg1;
    g.r2 = ex_reg2;        g.mux = ex_mux_res;   g.dest = ex_dest;
    g.bcnt = bubble_cnt;   g.fcnt = flush_cnt;
    return g;
  endfunction

  task automatic set_id(input logic v, input logic wb, input logic mr, input logic mw,
                        input logic [1:0] br, input logic [3:0] cmd, input logic [DW-1:0] pc,
                        input logic [AW-1:0] dest, input logic [AW-1:0] s1,
                        input logic [AW-1:0] s2, input logic us2);
    id_valid = v; id_wb_en = wb; id_mem_read = mr; id_mem_write = mw; id_branch_type = br;
    id_ex_cmd = cmd; id_pc = pc; id_reg1 = pc + 32'h100; id_reg2 = pc + 32'h200;
    id_mux_res = pc + 32'h300; id_dest = dest; id_src1 = s1; id_src2 = s2; id_uses_src2 = us2;
  endtask

  // Predict next EX state from the spec, queue it, clock, then pop and compare.
  task automatic tick();
    exp_t n;
    exp_t e;
    exp_t g;
    logic hz;
    #1;
    hz = m.valid && m.mr && (m.dest != '0) && id_valid &&
         ((id_src1 == m.dest) || (id_uses_src2 && (id_src2 == m.dest)));
    checks++;
    if (hazard_stall !== hz) begin
      errors++;
      $display("FAIL hazard_model got %b exp %b at %0t", hazard_stall, hz, $time);
    end
    n = m;
    if (!freeze) begin
      if (flush || hz) begin
        n = '0;
        n.bcnt = m.bcnt;
        n.fcnt = m.fcnt;
        if (flush) n.fcnt = (m.fcnt == {CW{1'b1}}) ? m.fcnt : m.fcnt + 1'b1;
        else       n.bcnt = (m.bcnt == {CW{1'b1}}) ? m.bcnt : m.bcnt + 1'b1;
      end else begin
        n.valid = id_valid;
        n.wb  = id_valid & id_wb_en;
        n.mr  = id_valid & id_mem_read;
        n.mw  = id_valid & id_mem_write;
        n.br  = id_valid ? id_branch_type : 2'b00;
        n.cmd = id_ex_cmd; n.pc = id_pc; n.r1 = id_reg1; n.r2 = id_reg2;
        n.mux = id_mux_res; n.dest = id_dest;
      end
    end
    exp_q.push_back(n);
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      g = outs();
      if (g !== e) begin
        errors++;
        $display("FAIL ex_bundle got %h exp %h at %0t", g, e, $time);
      end
      m = e;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
    m = '0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    exp_t g;
    #3;
    g = outs();
    checks++;
    if (g !== '0 || hazard_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial got %h hz %b exp 0", g, hazard_stall);
    end
    rst = 1'b1;
    set_id(1, 1, 1, 0, 2'b01, 4'h5, 32'h40, 5'd4, 5'd1, 5'd2, 1);
    tick();
    set_id(1, 1, 0, 1, 2'b10, 4'h6, 32'h44, 5'd6, 5'd4, 5'd2, 1);
    freeze = 1'b1;
    #1;
    checks++;
    if (hazard_stall !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_hazard got %b exp 1", hazard_stall);
    end
    rst = 1'b0;
    #1;
    g = outs();
    checks++;
    if (g !== '0 || hazard_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got %h hz %b exp 0", g, hazard_stall);
    end
    #3;
    rst = 1'b1;
    freeze = 1'b0;
    m = '0;
    exp_q.delete();
    tick();
    checks++;
    if (ex_pc !== 32'h44 || ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_no_residual got pc %h v %b exp 44 1", ex_pc, ex_valid);
    end
  endtask

  task automatic test_normal();
    set_id(1, 1, 0, 0, 2'b00, 4'h1, 32'h10, 5'd3, 5'd0, 5'd0, 0);
    id_reg1 = 32'd5; id_reg2 = 32'd7;
    tick();
    checks++;
    if (ex_pc !== 32'h10 || ex_reg1 !== 32'd5 || ex_reg2 !== 32'd7 || ex_dest !== 5'd3 ||
        ex_ex_cmd !== 4'h1 || ex_wb_en !== 1'b1 || ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL normal_pass got pc %h r1 %0d r2 %0d d %0d cmd %h wb %b v %b", ex_pc,
               ex_reg1, ex_reg2, ex_dest, ex_ex_cmd, ex_wb_en, ex_valid);
    end
    set_id(0, 1, 1, 1, 2'b11, 4'h2, 32'h14, 5'd3, 5'd0, 5'd0, 0);
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_wb_en !== 1'b0 || ex_mem_read !== 1'b0 ||
        ex_mem_write !== 1'b0 || ex_branch_type !== 2'b00) begin
      errors++;
      $display("FAIL invalid_ctrl got v%b wb%b mr%b mw%b br%b exp 0", ex_valid, ex_wb_en,
               ex_mem_read, ex_mem_write, ex_branch_type);
    end
  endtask

  task automatic test_load_use();
    logic [CW-1:0] b0;
    b0 = bubble_cnt;
    set_id(1, 1, 1, 0, 2'b00, 4'h3, 32'h20, 5'd4, 5'd0, 5'd0, 0);
    tick();
    set_id(1, 1, 0, 0, 2'b00, 4'h4, 32'h24, 5'd6, 5'd4, 5'd0, 0);
    #1;
    checks++;
    if (hazard_stall !== 1'b1) begin
      errors++;
      $display("FAIL load_use_stall got %b exp 1", hazard_stall);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_wb_en !== 1'b0 || bubble_cnt !== b0 + 1'b1) begin
      errors++;
      $display("FAIL load_use_bubble got v %b wb %b cnt %0d exp 0 0 %0d", ex_valid, ex_wb_en,
               bubble_cnt, b0 + 1'b1);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || ex_pc !== 32'h24) begin
      errors++;
      $display("FAIL load_use_enter got v %b pc %h exp 1 24", ex_valid, ex_pc);
    end
    // Immediate form: src2 matches but is not a real source.
    set_id(1, 1, 1, 0, 2'b00, 4'h3, 32'h28, 5'd4, 5'd0, 5'd0, 0);
    tick();
    set_id(1, 1, 0, 0, 2'b00, 4'h4, 32'h2c, 5'd6, 5'd9, 5'd4, 0);
    #1;
    checks++;
    if (hazard_stall !== 1'b0) begin
      errors++;
      $display("FAIL no_stall_imm got %b exp 0", hazard_stall);
    end
    tick();
    // Real src2 match stalls.
    set_id(1, 1, 1, 0, 2'b00, 4'h3, 32'h30, 5'd4, 5'd0, 5'd0, 0);
    tick();
    set_id(1, 0, 0, 1, 2'b00, 4'h7, 32'h34, 5'd0, 5'd9, 5'd4, 1);
    #1;
    checks++;
    if (hazard_stall !== 1'b1) begin
      errors++;
      $display("FAIL src2_stall got %b exp 1", hazard_stall);
    end
    tick();
    tick();
    // Load to r0 never stalls.
    set_id(1, 1, 1, 0, 2'b00, 4'h3, 32'h38, 5'd0, 5'd0, 5'd0, 0);
    tick();
    set_id(1, 1, 0, 0, 2'b00, 4'h4, 32'h3c, 5'd6, 5'd0, 5'd0, 1);
    #1;
    checks++;
    if (hazard_stall !== 1'b0) begin
      errors++;
      $display("FAIL no_stall_r0 got %b exp 0", hazard_stall);
    end
    tick();
  endtask

  task automatic test_flush();
    do_reset();
    set_id(1, 1, 0, 1, 2'b01, 4'h8, 32'h50, 5'd2, 5'd1, 5'd1, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (ex_valid !== 1'b0 || ex_mem_write !== 1'b0 || ex_branch_type !== 2'b00 ||
        flush_cnt !== 8'd1) begin
      errors++;
      $display("FAIL flush_bubble got v %b mw %b br %b fc %0d exp 0 0 00 1", ex_valid,
               ex_mem_write, ex_branch_type, flush_cnt);
    end
    do_reset();
    set_id(1, 1, 1, 0, 2'b00, 4'h3, 32'h54, 5'd5, 5'd0, 5'd0, 0);
    tick();
    set_id(1, 1, 0, 0, 2'b00, 4'h4, 32'h58, 5'd6, 5'd5, 5'd0, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (flush_cnt !== 8'd1 || bubble_cnt !== 8'd0 || ex_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_and_hazard got fc %0d bc %0d v %b exp 1 0 0", flush_cnt, bubble_cnt,
               ex_valid);
    end
  endtask

  task automatic test_freeze();
    logic [CW-1:0] b0;
    logic [CW-1:0] f0;
    set_id(1, 1, 0, 0, 2'b10, 4'h9, 32'h60, 5'd7, 5'd1, 5'd2, 1);
    tick();
    b0 = bubble_cnt;
    f0 = flush_cnt;
    freeze = 1'b1;
    flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_id(1, 0, 1, 1, 2'b11, 4'(i), 32'h70 + 32'(i) * 4, 5'd8, 5'd7, 5'd7, 1);
      tick();
      checks++;
      if (ex_pc !== 32'h60 || ex_valid !== 1'b1 || bubble_cnt !== b0 || flush_cnt !== f0) begin
        errors++;
        $display("FAIL freeze_hold got pc %h v %b bc %0d fc %0d exp 60 1 %0d %0d", ex_pc,
                 ex_valid, bubble_cnt, flush_cnt, b0, f0);
      end
    end
    freeze = 1'b0;
    flush = 1'b0;
    set_id(1, 1, 0, 0, 2'b00, 4'hA, 32'h80, 5'd9, 5'd1, 5'd2, 1);
    tick();
    checks++;
    if (ex_pc !== 32'h80 || ex_valid !== 1'b1 || ex_ex_cmd !== 4'hA) begin
      errors++;
      $display("FAIL freeze_release got pc %h v %b cmd %h exp 80 1 A", ex_pc, ex_valid,
               ex_ex_cmd);
    end
  endtask

  task automatic test_back_to_back();
    logic [CW-1:0] b0;
    b0 = bubble_cnt;
    set_id(1, 1, 1, 0, 2'b00, 4'h3, 32'h90, 5'd7, 5'd1, 5'd2, 1);
    tick();
    set_id(1, 1, 1, 0, 2'b00, 4'h3, 32'h94, 5'd7, 5'd7, 5'd2, 1);
    tick();
    tick();
    checks++;
    if (ex_pc !== 32'h94 || ex_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_load got pc %h v %b exp 94 1", ex_pc, ex_valid);
    end
    set_id(1, 1, 0, 0, 2'b00, 4'h1, 32'h98, 5'd8, 5'd3, 5'd7, 1);
    tick();
    tick();
    checks++;
    if (ex_pc !== 32'h98 || bubble_cnt !== b0 + 8'd2) begin
      errors++;
      $display("FAIL b2b_bubbles got pc %h bc %0d exp 98 %0d", ex_pc, bubble_cnt, b0 + 8'd2);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    set_id(1, 1, 1, 0, 2'b00, 4'h3, 32'hA0, 5'd4, 5'd4, 5'd0, 0);
    for (int i = 0; i < 2 * ((1 << CW) - 2); i++) tick();
    checks++;
    if (bubble_cnt !== {{(CW-1){1'b1}}, 1'b0}) begin
      errors++;
      $display("FAIL sat_preload got %h exp %h", bubble_cnt, {{(CW-1){1'b1}}, 1'b0});
    end
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (bubble_cnt !== {CW{1'b1}}) begin
      errors++;
      $display("FAIL bubble_sat got %h exp %h", bubble_cnt, {CW{1'b1}});
    end
    flush = 1'b1;
    for (int i = 0; i < (1 << CW) + 2; i++) tick();
    flush = 1'b0;
    checks++;
    if (flush_cnt !== {CW{1'b1}} || bubble_cnt !== {CW{1'b1}}) begin
      errors++;
      $display("FAIL flush_sat got fc %h bc %h exp all ones", flush_cnt, bubble_cnt);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_normal();
    test_load_use();
    test_flush();
    test_freeze();
    test_back_to_back();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
